arb_stream_mux: RTL and testbench

//  Parametrised N-channel, WIDTH-bit multiplexer with a valid/ready handshake on every channel.

---
 rtl/arb_stream_mux_pkg.sv | 15 +
 rtl/arb_stream_mux_rr_arbiter.sv | 44 ++++
 rtl/arb_stream_mux.sv | 90 +++++++++
 tb/tb_arb_stream_mux.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_stream_mux_pkg.sv
// Shared constants and helpers for the arbitrated stream multiplexer.
package mux_pkg;

   localparam int MUX_MODE_SELECT = 0;
   localparam int MUX_MODE_RR     = 1;

   // Channel-id width; a single channel still gets a 1-bit id port.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/arb_stream_mux_rr_arbiter.sv
// Round-robin arbiter: scans requests upward from rr_ptr, wrapping, and
// moves the pointer just past the granted channel on every accepted transfer.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int LENGTH     = 4,
   parameter int SEL_LENGTH = clog2_min1(LENGTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LENGTH-1:0]     req,
   input  logic                  advance,
   output logic [SEL_LENGTH-1:0] grant,
   output logic                  grant_valid
);

   logic [SEL_LENGTH-1:0] rr_ptr;
   int                    idx;

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int k = 0; k < LENGTH; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= LENGTH) idx = idx - LENGTH;
         for (int i = 0; i < LENGTH; i++) begin
            if (!grant_valid && (i == idx) && req[i]) begin
               grant       = SEL_LENGTH'(i);
               grant_valid = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= (int'(grant) == LENGTH - 1) ? '0 : grant + 1'b1;
      end
   end

endmodule

// File: rtl/arb_stream_mux.sv
// N-channel valid/ready multiplexer with a 1-entry registered output stage;
// channel chosen by the select port or by a round-robin arbiter.
module arb_stream_mux
   import mux_pkg::*;
#(
   parameter int LENGTH     = 4,
   parameter int WIDTH      = 16,
   parameter int SEL_LENGTH = clog2_min1(LENGTH),
   parameter int MODE       = MUX_MODE_SELECT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [LENGTH-1:0]       in_valid,
   input  logic [LENGTH*WIDTH-1:0] in_data,
   output logic [LENGTH-1:0]       in_ready,
   input  logic [SEL_LENGTH-1:0]   select,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_LENGTH-1:0]   out_chan,
   input  logic                    out_ready
);

   logic [SEL_LENGTH-1:0] g;
   logic                  grant_ok;
   logic                  can_load;
   logic                  xfer;
   logic [WIDTH-1:0]      g_data;
   logic                  g_valid;

   assign can_load = !out_valid || out_ready;

   generate
      if (MODE == MUX_MODE_RR) begin : g_rr
         logic unused_select;
         assign unused_select = ^select;
         rr_arbiter #(
            .LENGTH     (LENGTH),
            .SEL_LENGTH (SEL_LENGTH)
         ) u_arb (
            .clk         (clk),
            .rst_n       (rst_n),
            .req         (in_valid),
            .advance     (xfer),
            .grant       (g),
            .grant_valid (grant_ok)
         );
      end else if (LENGTH == 1) begin : g_one
         logic unused_select;
         assign unused_select = ^select;
         assign g        = '0;
         assign grant_ok = 1'b1;
      end else begin : g_sel
         // Out-of-range select grants nothing rather than aliasing a channel.
         assign g        = select;
         assign grant_ok = (int'(select) < LENGTH);
      end
   endgenerate

   always_comb begin
      g_data  = '0;
      g_valid = 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
         if (g == SEL_LENGTH'(i)) begin
            g_data  = in_data[i*WIDTH +: WIDTH];
            g_valid = in_valid[i];
         end
      end
   end

   assign xfer = rst_n && grant_ok && g_valid && can_load;

   for (genvar gi = 0; gi < LENGTH; gi++) begin : g_ready
      assign in_ready[gi] = rst_n && grant_ok && (g == SEL_LENGTH'(gi)) && can_load;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= g_data;
         out_chan  <= g;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_arb_stream_mux.sv
// Directed bench: four instances (select/RR at LENGTH 4 and 3) on shared stimulus.
module tb_arb_stream_mux;
   import mux_pkg::*;

   typedef struct packed {
      logic [1:0]  k;
      logic [15:0] d;
      logic [1:0]  c;
   } word_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [63:0] in_data;
   logic [1:0]  select;
   logic        out_ready;

   logic        ov [4];
   logic [15:0] od [4];
   logic [1:0]  oc [4];
   logic [3:0]  ir [4];
   logic [3:0]  ir_a, ir_b;
   logic [2:0]  ir_c, ir_d;

   word_t sbq[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   arb_stream_mux #(.LENGTH(4), .WIDTH(16), .MODE(MUX_MODE_SELECT)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(ir_a),
      .select(select), .out_valid(ov[0]), .out_data(od[0]), .out_chan(oc[0]), .out_ready(out_ready));
   arb_stream_mux #(.LENGTH(4), .WIDTH(16), .MODE(MUX_MODE_RR)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(ir_b),
      .select(select), .out_valid(ov[1]), .out_data(od[1]), .out_chan(oc[1]), .out_ready(out_ready));
   arb_stream_mux #(.LENGTH(3), .WIDTH(16), .MODE(MUX_MODE_RR)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2:0]), .in_data(in_data[47:0]), .in_ready(ir_c),
      .select(select), .out_valid(ov[2]), .out_data(od[2]), .out_chan(oc[2]), .out_ready(out_ready));
   arb_stream_mux #(.LENGTH(3), .WIDTH(16), .MODE(MUX_MODE_SELECT)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2:0]), .in_data(in_data[47:0]), .in_ready(ir_d),
      .select(select), .out_valid(ov[3]), .out_data(od[3]), .out_chan(oc[3]), .out_ready(out_ready));

   assign ir[0] = ir_a;
   assign ir[1] = ir_b;
   assign ir[2] = {1'b0, ir_c};
   assign ir[3] = {1'b0, ir_d};

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input int k, input logic [15:0] d, input int c);
      word_t w;
      w.k = 2'(k);
      w.d = d;
      w.c = 2'(c);
      sbq.push_back(w);
   endtask

   task automatic pop_check(input string tag);
      word_t w;
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=empty_scoreboard expected=word", tag);
      end else begin
         w = sbq.pop_front();
         $display("txn %s dut=%0d data=%h chan=%0d", tag, w.k, od[w.k], oc[w.k]);
         chk({tag, "_valid"}, 32'(ov[w.k]), 32'd1);
         chk({tag, "_data"},  32'(od[w.k]), 32'(w.d));
         chk({tag, "_chan"},  32'(oc[w.k]), 32'(w.c));
      end
   endtask

   task automatic set_data(input logic [15:0] base);
      for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = base + 16'(i);
   endtask

   task automatic rst_pulse();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_ir [4];
      int         seq13 [4];
      exp_ir = '{4'b0100, 4'b0001, 4'b0001, 4'b0100};
      seq13  = '{1, 3, 1, 3};

      // 1. reset with all channels valid
      rst_n = 1'b0; in_valid = 4'hF; select = 2'd2; out_ready = 1'b1;
      set_data(16'h1000);
      cyc(); cyc();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'd0);
         chk($sformatf("rst_data%0d", k),  32'(od[k]), 32'd0);
         chk($sformatf("rst_ready%0d", k), 32'(ir[k]), 32'd0);
      end
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("first_ready%0d", k), 32'(ir[k]), 32'(exp_ir[k]));
         chk($sformatf("first_pre%0d", k),   32'(ov[k]), 32'd0);
      end
      push(0, 16'h1002, 2); push(1, 16'h1000, 0); push(2, 16'h1000, 0); push(3, 16'h1002, 2);
      cyc();
      for (int k = 0; k < 4; k++) pop_check($sformatf("first%0d", k));

      // 2. select streaming, back-to-back
      in_data[47:32] = 16'hA5A5;
      #1;
      chk("sel_ready", 32'(ir[0]), 32'b0100);
      push(0, 16'hA5A5, 2);
      cyc(); pop_check("stream0");
      in_data[47:32] = 16'h5A5A;
      push(0, 16'h5A5A, 2);
      cyc(); pop_check("stream1");

      // 3. back-pressure then drain+load in one edge
      out_ready = 1'b0;
      in_data[47:32] = 16'h1234;
      for (int n = 0; n < 3; n++) begin
         #1;
         chk($sformatf("stall_ready%0d", n), 32'(ir[0]), 32'd0);
         cyc();
         chk($sformatf("stall_data%0d", n),  32'(od[0]), 32'h5A5A);
         chk($sformatf("stall_valid%0d", n), 32'(ov[0]), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("unstall_ready", 32'(ir[0]), 32'b0100);
      push(0, 16'h1234, 2);
      cyc(); pop_check("unstall");

      // 4. round-robin fairness
      rst_pulse();
      set_data(16'hC000); in_valid = 4'hF;
      for (int n = 0; n < 6; n++) begin
         #1;
         chk($sformatf("rr_ready%0d", n), 32'(ir[1]), 32'd1 << (n % 4));
         push(1, 16'hC000 + 16'(n % 4), n % 4);
         cyc(); pop_check($sformatf("rr%0d", n));
      end
      rst_pulse();
      in_valid = 4'b1010;
      for (int n = 0; n < 4; n++) begin
         push(1, 16'hC000 + 16'(seq13[n]), seq13[n]);
         cyc(); pop_check($sformatf("rr13_%0d", n));
      end

      // 5. wrap at LENGTH=3, then illegal select
      rst_pulse();
      in_valid = 4'b0100;
      #1;
      chk("wrap_ready2", 32'(ir[2]), 32'b0100);
      push(2, 16'hC002, 2);
      cyc(); pop_check("wrap2");
      in_valid = 4'b0111;
      #1;
      chk("wrap_ready0", 32'(ir[2]), 32'b0001);
      push(2, 16'hC000, 0);
      cyc(); pop_check("wrap0");
      push(2, 16'hC001, 1);
      cyc(); pop_check("wrap1");
      select = 2'd3; in_valid = 4'hF;
      #1;
      chk("illegal_ready", 32'(ir[3]), 32'd0);
      chk("legal3_ready",  32'(ir[0]), 32'b1000);
      cyc(); cyc();
      chk("illegal_drained", 32'(ov[3]), 32'd0);
      chk("illegal_ready2",  32'(ir[3]), 32'd0);
      select = 2'd2; in_valid = 4'h0;
      #1;
      chk("sel_no_valid_ready", 32'(ir[0]), 32'b0100);

      // 6. asynchronous reset while stalled
      rst_pulse();
      in_valid = 4'hF; out_ready = 1'b1;
      set_data(16'hD000);
      push(1, 16'hD000, 0);
      cyc(); pop_check("pre_stall");
      out_ready = 1'b0;
      cyc();
      chk("hold_valid", 32'(ov[1]), 32'd1);
      chk("hold_data",  32'(od[1]), 32'hD000);
      chk("hold_ready", 32'(ir[1]), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(ov[1]), 32'd0);
      chk("async_data",  32'(od[1]), 32'd0);
      cyc();
      rst_n = 1'b1; out_ready = 1'b1;
      #1;
      chk("restart_ready", 32'(ir[1]), 32'b0001);
      push(1, 16'hD000, 0);
      cyc(); pop_check("restart");

      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
